sync_fifo_param: RTL

Parametrised single-clock FIFO, the next generation of the team's FIFO buffer. Generalises data width and depth, including non-power-of-two depths. Adds occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. Sits between producer and consumer blocks in the same clock domain.

---
 rtl/sync_fifo_param.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, thresholds,
// overflow/underflow pulses and optional first-word-fall-through reads.
module sync_fifo_param #(
  parameter int DATAWIDTH = 8,
  parameter int FIFODEPTH = 16,
  parameter int PTRWIDTH  = $clog2(FIFODEPTH),
  parameter int AF_THRESH = FIFODEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 o_fifo_full,
  output logic                 o_fifo_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic [PTRWIDTH:0]    o_count,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam int CW = PTRWIDTH + 1;

  localparam logic [CW-1:0] C_DEPTH = CW'(FIFODEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);
  localparam logic [CW-1:0] C_CONE  = CW'(1);

  localparam logic [PTRWIDTH-1:0] C_LAST = PTRWIDTH'(FIFODEPTH - 1);
  localparam logic [PTRWIDTH-1:0] C_PONE = PTRWIDTH'(1);

  if (FIFODEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_param: FIFODEPTH must be >= 2");
  end
  if (PTRWIDTH < $clog2(FIFODEPTH)) begin : g_bad_ptrw
    $error("sync_fifo_param: PTRWIDTH too narrow for FIFODEPTH");
  end
  if ((AF_THRESH < 0) || (AF_THRESH > FIFODEPTH)) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH outside 0..FIFODEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > FIFODEPTH)) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH outside 0..FIFODEPTH");
  end

  logic [DATAWIDTH-1:0] r_mem [FIFODEPTH];

  logic [PTRWIDTH-1:0]  r_wr_ptr;
  logic [PTRWIDTH-1:0]  r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [DATAWIDTH-1:0] r_rd_data;
  logic                 r_ovf;
  logic                 r_unf;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic [PTRWIDTH-1:0]  w_wr_ptr_nxt;
  logic [PTRWIDTH-1:0]  w_rd_ptr_nxt;

  assign w_full   = (r_count == C_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_rd_acc = rd_en & ~w_empty;
  assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

  // Wrap at FIFODEPTH-1 so non-power-of-two depths work.
  assign w_wr_ptr_nxt = (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + C_PONE;
  assign w_rd_ptr_nxt = (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + C_PONE;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_rd_acc) begin
        r_rd_ptr  <= w_rd_ptr_nxt;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + C_CONE;
        2'b01:   r_count <= r_count - C_CONE;
        default: r_count <= r_count;
      endcase
      r_ovf <= wr_en & ~w_wr_acc;
      r_unf <= rd_en & ~w_rd_acc;
    end
  end

  // r_rd_data holds the last popped word, which is what FWFT shows when empty.
  if (FWFT) begin : g_fwft
    assign rd_data = w_empty ? r_rd_data : r_mem[r_rd_ptr];
  end else begin : g_std
    assign rd_data = r_rd_data;
  end

  assign o_fifo_full    = w_full;
  assign o_fifo_empty   = w_empty;
  assign o_almost_full  = (r_count >= C_AF);
  assign o_almost_empty = (r_count <= C_AE);
  assign o_count        = r_count;
  assign o_overflow     = r_ovf;
  assign o_underflow    = r_unf;

endmodule
